fwd_ctrl: RTL and testbench
===========================

FWD_CTRL -- requirements
Module: fwd_ctrl

Interface
REQ-001 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Port: rst  input  1  reset, asynchronous, active-high.
REQ-003 Port: id_valid  input  1  ID-stage slot holds a real instruction.
REQ-004 Port: id_rs, id_rt  input  5 each  ID source register numbers.
REQ-005 Port: id_use_rs, id_use_rt  input  1 each  source actually read.
REQ-006 Port: id_wreg  input  1  ID instruction writes a register.
REQ-007 Port: id_wa  input  5  ID destination register number.
REQ-008 Port: id_rtype  input  2  result kind: 00 ALU, 01 LOAD, 10 HILO, 11 LINK.
REQ-009 Port: flush  input  1  squash the ID instruction (branch/exception redirect).
REQ-010 Port: sel_a, sel_b  output  3 each  registered select codes for the EX-stage operand A/B 5-way muxes.
REQ-011 Port: stall  output  1  combinational; hold PC and IF/ID, bubble EX.

Function
REQ-012 Select codes SHALL be: 000 regfile, 001 EX/MEM ALU result, 010 MEM/WB write-back data, 011 EX/MEM HILO, 100 EX/MEM link address; 101-111 never driven.
REQ-013 Block SHALL keep two shadow stages, EXs and MEMs, each {valid, wreg, wa, rtype}, mirroring the instructions currently in EX and MEM.
REQ-014 On an advancing edge (no stall, no flush), EXs SHALL load the ID fields (valid = id_valid) and MEMs SHALL load EXs.
REQ-015 On a stall edge, MEMs SHALL load EXs and EXs SHALL load a bubble (valid = 0).
REQ-016 On a flush edge, EXs SHALL load a bubble, MEMs SHALL load EXs, and sel_a/sel_b SHALL load 000; flush has priority over stall.
REQ-017 A shadow stage "matches" a source when valid & wreg & wa == src & src != 0 & the corresponding id_use bit is set.
REQ-018 For each operand, the next sel SHALL be chosen with priority: EXs match (by EXs.rtype: ALU 001, HILO 011, LINK 100) > MEMs match (010) > 000.
REQ-019 stall SHALL be 1 when id_valid, flush = 0, and EXs matches either source with EXs.rtype = LOAD; otherwise 0.
REQ-020 On a stall edge, sel_a/sel_b SHALL load 000; the cycle after, the load sits in MEMs and the held ID instruction SHALL receive 010.
REQ-021 Latency: sel codes are valid in the cycle the instruction occupies EX, exactly one edge after it leaves ID.
REQ-022 Register 0 SHALL never be forwarded or cause a stall, regardless of wreg.
REQ-023 Both operands naming the same register SHALL receive identical codes.

Reset
REQ-024 While rst = 1: EXs.valid = 0, MEMs.valid = 0, sel_a = sel_b = 000, stall = 0, independent of clk.
REQ-025 Reset deassertion mid-stream SHALL produce no forwarding until new instructions are issued through ID.

Structure
REQ-026 Select codes and rtype encodings SHALL be constants in the shared CPU definitions package, also used by the datapath mux instances.
REQ-027 One sub-module, fwd_pick, SHALL compute a single operand's code and load-hazard flag; fwd_ctrl instantiates it twice.

Verification
REQ-028 ALU chain: issue add $3 then sub $4,$3,$5 -> sub in EX with sel_a = 001, sel_b = 000, stall never 1.
REQ-029 Load-use: lw $2 then add $6,$2,$2 -> stall = 1 for exactly one cycle, then sel_a = sel_b = 010.
REQ-030 Distance 2: add $7; nop; or $8,$7,$0 -> sel_a = 010, sel_b = 000.
REQ-031 Priority: add $9; mfhi $9; and $1,$9,$9 -> sel_a = sel_b = 011 (newer HILO wins over older ALU).
REQ-032 $0 and flush: write $0 then read $0 -> 000; flush asserted with a load-use pending -> stall = 0, next sels = 000, EX bubble.
REQ-033 Async reset asserted mid-sequence between clock edges -> sel_a = sel_b = 000 and stall = 0 immediately; the next read of a previously written register -> 000.

Source files
------------

// File: rtl/fwd_ctrl_pkg.sv
// Shared CPU definitions: result-kind encodings, EX operand mux select codes,
// and the pipeline shadow-stage record used by the forwarding control.
// Ports: none (package).
package fwd_ctrl_pkg;

  // Result kind of an instruction, as carried down the pipeline.
  typedef enum logic [1:0] {
    RT_ALU  = 2'b00,
    RT_LOAD = 2'b01,
    RT_HILO = 2'b10,
    RT_LINK = 2'b11
  } rtype_e;

  // Select codes for the EX-stage operand A/B 5-way muxes.
  localparam logic [2:0] SEL_RF       = 3'b000; // register file read data
  localparam logic [2:0] SEL_EXM_ALU  = 3'b001; // EX/MEM ALU result
  localparam logic [2:0] SEL_MEMWB    = 3'b010; // MEM/WB write-back data
  localparam logic [2:0] SEL_EXM_HILO = 3'b011; // EX/MEM HI/LO value
  localparam logic [2:0] SEL_EXM_LINK = 3'b100; // EX/MEM link address

  // Destination bookkeeping for one pipeline stage.
  typedef struct packed {
    logic       valid;
    logic       wreg;
    logic [4:0] wa;
    rtype_e     rtype;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{valid: 1'b0, wreg: 1'b0, wa: 5'd0, rtype: RT_ALU};

  // True when stage s produces the register that the ID instruction really reads.
  // Register 0 is hard-wired to zero, so it never matches.
  function automatic logic stage_hits(input shadow_t s, input logic [4:0] src, input logic use_src);
    return s.valid & s.wreg & (s.wa == src) & (src != 5'd0) & use_src;
  endfunction

endpackage

// File: rtl/fwd_ctrl_pick.sv
// Forwarding pick for one EX operand: chooses the mux select code and flags a
// load-use hazard against the instruction currently in EX.
// Ports: src_i/use_i (ID source reg and whether it is read), exs_i/mems_i
// (EX and MEM shadow stages), sel_o (next select code), load_haz_o.
module fwd_pick
  import fwd_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  shadow_t    exs_i,
  input  shadow_t    mems_i,
  output logic [2:0] sel_o,
  output logic       load_haz_o
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = stage_hits(exs_i, src_i, use_i);
  assign mem_hit = stage_hits(mems_i, src_i, use_i);

  always_comb begin
    sel_o      = SEL_RF;
    load_haz_o = 1'b0;
    if (ex_hit) begin
      // The youngest producer wins. A load in EX has no data yet; the caller
      // stalls and the code is irrelevant, so leave it at register file.
      unique case (exs_i.rtype)
        RT_ALU:  sel_o = SEL_EXM_ALU;
        RT_HILO: sel_o = SEL_EXM_HILO;
        RT_LINK: sel_o = SEL_EXM_LINK;
        RT_LOAD: begin
          sel_o      = SEL_RF;
          load_haz_o = 1'b1;
        end
        default: sel_o = SEL_RF;
      endcase
    end else if (mem_hit) begin
      sel_o = SEL_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use interlock control for a 5-stage pipeline.
// Tracks destination info for the EX and MEM stages and registers the EX
// operand select codes one edge after the instruction leaves ID.
// Ports: clk, rst (async, active-high); id_* describe the ID instruction;
// flush squashes it; sel_a/sel_b are registered mux selects; stall is
// combinational and holds PC/IF-ID while bubbling EX.
module fwd_ctrl
  import fwd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_wreg,
  input  logic [4:0] id_wa,
  input  logic [1:0] id_rtype,
  input  logic       flush,
  output logic [2:0] sel_a,
  output logic [2:0] sel_b,
  output logic       stall
);

  shadow_t    exs_q,   exs_d;
  shadow_t    mems_q,  mems_d;
  logic [2:0] sel_a_q, sel_a_d;
  logic [2:0] sel_b_q, sel_b_d;

  logic [2:0] pick_a, pick_b;
  logic       haz_a,  haz_b;

  fwd_pick u_pick_a (
    .src_i      (id_rs),
    .use_i      (id_use_rs),
    .exs_i      (exs_q),
    .mems_i     (mems_q),
    .sel_o      (pick_a),
    .load_haz_o (haz_a)
  );

  fwd_pick u_pick_b (
    .src_i      (id_rt),
    .use_i      (id_use_rt),
    .exs_i      (exs_q),
    .mems_i     (mems_q),
    .sel_o      (pick_b),
    .load_haz_o (haz_b)
  );

  always_comb begin
    // Flush overrides the interlock: the stalled instruction is being squashed.
    stall   = id_valid & ~flush & (haz_a | haz_b);
    mems_d  = exs_q;
    exs_d   = SHADOW_BUBBLE;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (!flush && !stall) begin
      exs_d   = '{valid: id_valid, wreg: id_wreg, wa: id_wa, rtype: rtype_e'(id_rtype)};
      sel_a_d = pick_a;
      sel_b_d = pick_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exs_q   <= SHADOW_BUBBLE;
      mems_q  <= SHADOW_BUBBLE;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else begin
      exs_q   <= exs_d;
      mems_q  <= mems_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt;
  logic       id_use_rs, id_use_rt;
  logic       id_wreg;
  logic [4:0] id_wa;
  logic [1:0] id_rtype;
  logic       flush;
  logic [2:0] sel_a, sel_b;
  logic       stall;

  int n_pass  = 0;
  int n_total = 0;

  fwd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_wreg   (id_wreg),
    .id_wa     (id_wa),
    .id_rtype  (id_rtype),
    .flush     (flush),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt, wreg;
    logic [4:0] wa;
    logic [1:0] k;
    logic       fl;
    logic       xst;   // expected stall before the edge
    logic [2:0] xa, xb; // expected sel_a/sel_b after the edge
  } vec_t;

  vec_t tbl[$];

  localparam logic [1:0] K_ALU = 2'b00, K_LD = 2'b01, K_HILO = 2'b10, K_LINK = 2'b11;

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic wreg,
                              input logic [4:0] wa, input logic [1:0] k, input logic fl,
                              input logic xst, input logic [2:0] xa, input logic [2:0] xb);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.wreg = wreg;
    r.wa = wa; r.k = k; r.fl = fl; r.xst = xst; r.xa = xa; r.xb = xb;
    return r;
  endfunction

  function automatic vec_t bub();
    return mk(0, 0, 0, 0, 0, 0, 0, K_ALU, 0, 0, 3'b000, 3'b000);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs = t.rs; id_rt = t.rt; id_use_rs = t.urs; id_use_rt = t.urt;
    id_wreg = t.wreg; id_wa = t.wa; id_rtype = t.k; flush = t.fl;
  endtask

  // Drive just after a rising edge, check stall mid-cycle, check sels after the edge.
  task automatic apply(input vec_t t, input string tag);
    drive(t);
    @(negedge clk);
    check($sformatf("%s stall", tag), int'(stall), int'(t.xst));
    @(posedge clk);
    #1;
    check($sformatf("%s sel_a", tag), int'(sel_a), int'(t.xa));
    check($sformatf("%s sel_b", tag), int'(sel_b), int'(t.xb));
  endtask

  initial begin
    rst = 1'b1;
    drive(mk(1, 5'd3, 5'd3, 1, 1, 1, 5'd3, K_LD, 0, 0, 0, 0));

    // ALU chain
    tbl.push_back(mk(1, 5'd1, 5'd2, 1, 1, 1, 5'd3,  K_ALU, 0, 0, 3'b000, 3'b000)); // add $3
    tbl.push_back(mk(1, 5'd3, 5'd5, 1, 1, 1, 5'd4,  K_ALU, 0, 0, 3'b001, 3'b000)); // sub $4,$3,$5
    tbl.push_back(bub()); tbl.push_back(bub());
    // Load-use
    tbl.push_back(mk(1, 5'd1, 5'd0, 1, 0, 1, 5'd2,  K_LD,  0, 0, 3'b000, 3'b000)); // lw $2
    tbl.push_back(mk(1, 5'd2, 5'd2, 1, 1, 1, 5'd6,  K_ALU, 0, 1, 3'b000, 3'b000)); // add $6 stalls
    tbl.push_back(mk(1, 5'd2, 5'd2, 1, 1, 1, 5'd6,  K_ALU, 0, 0, 3'b010, 3'b010)); // held add
    tbl.push_back(bub()); tbl.push_back(bub());
    // Distance 2
    tbl.push_back(mk(1, 5'd1, 5'd1, 1, 1, 1, 5'd7,  K_ALU, 0, 0, 3'b000, 3'b000)); // add $7
    tbl.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0,  K_ALU, 0, 0, 3'b000, 3'b000)); // nop
    tbl.push_back(mk(1, 5'd7, 5'd0, 1, 1, 1, 5'd8,  K_ALU, 0, 0, 3'b010, 3'b000)); // or $8,$7,$0
    tbl.push_back(bub()); tbl.push_back(bub());
    // Priority: newer HILO over older ALU
    tbl.push_back(mk(1, 5'd0, 5'd0, 0, 0, 1, 5'd9,  K_ALU,  0, 0, 3'b000, 3'b000)); // add $9
    tbl.push_back(mk(1, 5'd0, 5'd0, 0, 0, 1, 5'd9,  K_HILO, 0, 0, 3'b000, 3'b000)); // mfhi $9
    tbl.push_back(mk(1, 5'd9, 5'd9, 1, 1, 1, 5'd1,  K_ALU,  0, 0, 3'b011, 3'b011)); // and $1,$9,$9
    tbl.push_back(bub()); tbl.push_back(bub());
    // Register 0: a load to $0 never stalls or forwards
    tbl.push_back(mk(1, 5'd0, 5'd0, 0, 0, 1, 5'd0,  K_LD,  0, 0, 3'b000, 3'b000));
    tbl.push_back(mk(1, 5'd0, 5'd0, 1, 1, 1, 5'd5,  K_ALU, 0, 0, 3'b000, 3'b000));
    tbl.push_back(mk(1, 5'd0, 5'd0, 1, 1, 0, 5'd0,  K_ALU, 0, 0, 3'b000, 3'b000));
    tbl.push_back(bub()); tbl.push_back(bub());
    // Link forward on operand B only
    tbl.push_back(mk(1, 5'd0, 5'd0, 0, 0, 1, 5'd31, K_LINK, 0, 0, 3'b000, 3'b000)); // jal
    tbl.push_back(mk(1, 5'd4, 5'd31, 1, 1, 1, 5'd6, K_ALU,  0, 0, 3'b000, 3'b100));
    tbl.push_back(bub()); tbl.push_back(bub());
    // Unused source bit suppresses a match
    tbl.push_back(mk(1, 5'd0, 5'd0, 0, 0, 1, 5'd12, K_ALU, 0, 0, 3'b000, 3'b000));
    tbl.push_back(mk(1, 5'd12, 5'd12, 0, 1, 0, 5'd0, K_ALU, 0, 0, 3'b000, 3'b001));
    tbl.push_back(bub()); tbl.push_back(bub());
    // Flush with load-use pending
    tbl.push_back(mk(1, 5'd1, 5'd0, 1, 0, 1, 5'd5,  K_LD,  0, 0, 3'b000, 3'b000)); // lw $5
    tbl.push_back(mk(1, 5'd5, 5'd5, 1, 1, 1, 5'd10, K_ALU, 1, 0, 3'b000, 3'b000)); // flushed add $10
    tbl.push_back(mk(1, 5'd5, 5'd10, 1, 1, 0, 5'd0, K_ALU, 0, 0, 3'b010, 3'b000)); // lw in MEM, $10 gone
    tbl.push_back(bub()); tbl.push_back(bub());

    // Reset state, held across edges
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", int'(stall), 0);
    check("reset sel_a", int'(sel_a), 0);
    check("reset sel_b", int'(sel_b), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(bub());
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Async reset mid-cycle
    apply(mk(1, 5'd0, 5'd0, 0, 0, 1, 5'd11, K_ALU, 0, 0, 3'b000, 3'b000), "ar add");
    apply(mk(1, 5'd11, 5'd0, 1, 0, 1, 5'd12, K_LD, 0, 0, 3'b001, 3'b000), "ar lw");
    drive(mk(1, 5'd12, 5'd11, 1, 1, 1, 5'd13, K_ALU, 0, 0, 0, 0));
    @(negedge clk);
    check("ar pre stall", int'(stall), 1);
    #1 rst = 1'b1;
    #1;
    check("ar in stall", int'(stall), 0);
    check("ar in sel_a", int'(sel_a), 0);
    check("ar in sel_b", int'(sel_b), 0);
    drive(bub());
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply(mk(1, 5'd12, 5'd11, 1, 1, 1, 5'd13, K_ALU, 0, 0, 3'b000, 3'b000), "ar post");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Guard against an unterminated run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_total);
    $fatal(1);
  end

endmodule
